// File: rtl/button_event_scheduler.sv
// button_event_scheduler: merges per-button press and auto-repeat events into one ordered stream.
// Auto-repeat FSMs and counters exist only when BTN_AUTOREPEAT_EN is defined.
module button_event_scheduler #(
   parameter int NUM_BTNS      = 4,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int FIFO_DEPTH    = 4,
   localparam int IDW          = $clog2(NUM_BTNS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BTNS-1:0] btn_state,
   input  logic [NUM_BTNS-1:0] btn_down,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [IDW-1:0]      evt_id,
   output logic                evt_repeat,
   output logic                evt_merged
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [NUM_BTNS-1:0] tick;
   logic [NUM_BTNS-1:0] pend_q, pend_d;
   logic [NUM_BTNS-1:0] rep_q, rep_d;
   logic [NUM_BTNS-1:0] grant;
   logic [NUM_BTNS-1:0] merge;
   logic [IDW-1:0]      rr_q, rr_d;
   logic [IDW-1:0]      gnt_idx;
   logic                gnt_vld;
   logic                merged_q;

   logic [IDW:0]        fifo_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [CW-1:0]       cnt_q;
   logic                full, push, pop;

`ifdef BTN_AUTOREPEAT_EN
   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(MAXC);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} rpt_state_e;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_rpt
      rpt_state_e    st_q, st_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic          tick_q, tick_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q   <= ST_IDLE;
            tmr_q  <= '0;
            tick_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            tick_q <= tick_d;
         end
      end

      // Tick is registered, so it appears one cycle after the terminal count.
      always_comb begin
         st_d   = st_q;
         tmr_d  = tmr_q;
         tick_d = 1'b0;
         if (btn_down[i]) begin
            st_d  = ST_HOLD;
            tmr_d = '0;
         end else if (st_q != ST_IDLE) begin
            if (!btn_state[i]) begin
               st_d  = ST_IDLE;
               tmr_d = '0;
            end else if (st_q == ST_HOLD && int'(tmr_q) == HOLD_CYCLES - 1) begin
               st_d   = ST_RPT;
               tmr_d  = '0;
               tick_d = 1'b1;
            end else if (st_q == ST_RPT && int'(tmr_q) == REPEAT_CYCLES - 1) begin
               tmr_d  = '0;
               tick_d = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
      end

      assign tick[i] = tick_q;
   end
`else
   logic unused_cfg;
   assign tick       = '0;
   assign unused_cfg = ^{btn_state, fifo_q[rd_q][0]};
`endif

   // A fresh press always wins over a repeat flag; a merge only counts if the slot was not just granted.
   always_comb begin
      pend_d = pend_q;
      rep_d  = rep_q;
      merge  = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (btn_down[i] || tick[i]) begin
            merge[i]  = pend_q[i] & ~grant[i];
            pend_d[i] = 1'b1;
            if (btn_down[i])
               rep_d[i] = 1'b0;
            else if (!(pend_q[i] && !grant[i]))
               rep_d[i] = 1'b1;
         end else if (grant[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      int            sum;
      logic [IDW-1:0] cand;
      grant   = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      sum     = 0;
      cand    = '0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         sum  = int'(rr_q) + k;
         cand = (sum >= NUM_BTNS) ? IDW'(sum - NUM_BTNS) : IDW'(sum);
         if (!gnt_vld && !full && pend_q[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_vld)
         grant[gnt_idx] = 1'b1;
      rr_d = rr_q;
      if (gnt_vld)
         rr_d = (int'(gnt_idx) == NUM_BTNS - 1) ? '0 : gnt_idx + 1'b1;
   end

   assign full = (cnt_q == CW'(FIFO_DEPTH));
   assign push = gnt_vld;
   assign pop  = evt_valid & evt_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= '0;
         rep_q    <= '0;
         rr_q     <= '0;
         merged_q <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         pend_q   <= pend_d;
         rep_q    <= rep_d;
         rr_q     <= rr_d;
         merged_q <= |merge;
         if (push)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage holds data only; outputs are gated by occupancy so reset needs no clear here.
   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_q] <= {gnt_idx, rep_q[gnt_idx]};
   end

   assign evt_valid  = (cnt_q != '0);
   assign evt_id     = evt_valid ? fifo_q[rd_q][IDW:1] : '0;
`ifdef BTN_AUTOREPEAT_EN
   assign evt_repeat = evt_valid & fifo_q[rd_q][0];
`else
   assign evt_repeat = 1'b0;
`endif
   assign evt_merged = merged_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler (4 buttons, HOLD=8, REPEAT=4, depth 4).
module tb_button_event_scheduler;
   localparam int NB  = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NB-1:0]  btn_state = '0;
   logic [NB-1:0]  btn_down = '0;
   logic           evt_valid;
   logic           evt_ready = 1'b0;
   logic [IDW-1:0] evt_id;
   logic           evt_repeat;
   logic           evt_merged;

   int n_chk = 0;
   int n_bad = 0;

   button_event_scheduler #(
      .NUM_BTNS(NB), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_state(btn_state), .btn_down(btn_down),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_repeat(evt_repeat), .evt_merged(evt_merged)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      btn_down  = '0;
      btn_state = '0;
      evt_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   // Presses buttons 0..3 with ready low, then leaves FIFO full.
   task automatic fill4();
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         btn_down = NB'(1 << i);
         step();
      end
      btn_down = '0;
      step();
   endtask

   initial begin
      int exp_ids[5];
      logic exp_v;
      logic exp_r;

      // Reset state
      rst_n = 1'b0;
      repeat (2) step();
      chk("rst_valid", evt_valid, 0);
      chk("rst_id", evt_id, 0);
      chk("rst_repeat", evt_repeat, 0);
      chk("rst_merged", evt_merged, 0);
      rst_n = 1'b1;
      repeat (7) step();

      // Single press on button 2: valid two cycles later, for one cycle
      evt_ready = 1'b1;
      btn_down  = 4'b0100;
      step();
      btn_down = '0;
      chk("single_c1_valid", evt_valid, 0);
      step();
      chk("single_c2_valid", evt_valid, 1);
      chk("single_c2_id", evt_id, 2);
      chk("single_c2_rep", evt_repeat, 0);
      step();
      chk("single_c3_valid", evt_valid, 0);

      // Two simultaneous bursts, both served 0..3
      do_reset();
      evt_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         btn_down = 4'b1111;
         step();
         btn_down = '0;
         step();
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst%0d_valid%0d", b, i), evt_valid, 1);
            chk($sformatf("burst%0d_id%0d", b, i), evt_id, i);
            step();
         end
         chk($sformatf("burst%0d_end", b), evt_valid, 0);
      end

      // Full FIFO holds 0..3, fifth press waits as pending, no merge
      fill4();
      btn_down = 4'b0001;
      step();
      btn_down = '0;
      chk("full_merged", evt_merged, 0);
      chk("full_valid", evt_valid, 1);
      chk("full_head", evt_id, 0);
      step();
      chk("full_head_stable", evt_id, 0);
      chk("full_merged2", evt_merged, 0);
      evt_ready = 1'b1;
      exp_ids = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain_valid%0d", i), evt_valid, 1);
         chk($sformatf("drain_id%0d", i), evt_id, exp_ids[i]);
         step();
      end
      chk("drain_end", evt_valid, 0);

      // Merge: button 1 pending while full, second press merges
      fill4();
      btn_down = 4'b0010;
      step();
      chk("merge_p6", evt_merged, 0);
      btn_down = 4'b0010;
      step();
      btn_down = '0;
      chk("merge_p7", evt_merged, 1);
      step();
      chk("merge_p8", evt_merged, 0);
      evt_ready = 1'b1;
      exp_ids = '{0, 1, 2, 3, 1};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("mdrain_valid%0d", i), evt_valid, 1);
         chk($sformatf("mdrain_id%0d", i), evt_id, exp_ids[i]);
         step();
      end
      chk("mdrain_end", evt_valid, 0);

      // Hold button 3 for 20 cycles
      do_reset();
      evt_ready = 1'b1;
      btn_down  = 4'b1000;
      btn_state = 4'b1000;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 1)
            btn_down = '0;
         if (k == 20)
            btn_state = '0;
`ifdef BTN_AUTOREPEAT_EN
         exp_v = (k == 2) || (k == 11) || (k == 15) || (k == 19);
         exp_r = (k != 2);
`else
         exp_v = (k == 2);
         exp_r = 1'b0;
`endif
         chk($sformatf("hold_valid_k%0d", k), evt_valid, exp_v);
         if (exp_v) begin
            chk($sformatf("hold_id_k%0d", k), evt_id, 3);
            chk($sformatf("hold_rep_k%0d", k), evt_repeat, exp_r);
         end
      end

      // Reset mid-transfer discards queued events
      do_reset();
      for (int i = 0; i < 3; i++) begin
         btn_down = NB'(1 << i);
         step();
      end
      btn_down = '0;
      step();
      chk("midrst_pre_valid", evt_valid, 1);
      evt_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", evt_valid, 0);
      chk("midrst_id", evt_id, 0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("midrst_after%0d", i), evt_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
